// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered ALU for the RV32 core.
//   Single-cycle basic ops (ADD..SRA) and, when SEQ_ALU_MULDIV_EN is defined,
//   iterative RV32M multiply/divide (shift-add / restoring, one bit per cycle).
//   Without SEQ_ALU_MULDIV_EN the mul/div datapath and the BUSY state are not
//   built, and opcodes 10-17 report Illegal with latency 1.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid / in_ready           operand handshake (in_ready high only in IDLE)
//   SrcA, SrcB, ALUControl        operands and 5-bit opcode, captured on accept
//   out_valid / out_ready         result handshake (held stable until taken)
//   Result                        registered result
//   Zero                          Result == 0
//   SignedLess, UnsignedLess      signed / unsigned A < B of the captured operands
//   Illegal                       opcode undefined or compiled out
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             SignedLess,
  output logic             UnsignedLess,
  output logic             Illegal
);

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h02;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_XOR   = 5'h04;
  localparam logic [4:0] OP_SLTU  = 5'h05;
  localparam logic [4:0] OP_SLT   = 5'h06;
  localparam logic [4:0] OP_PASSB = 5'h07;
  localparam logic [4:0] OP_SLL   = 5'h08;
  localparam logic [4:0] OP_SRL   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state, state_n;

  function automatic logic [WIDTH-1:0] basic_op(input logic [4:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLTU:  r = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLT:   r = {{(WIDTH-1){1'b0}}, sa < sb};
      OP_PASSB: r = b;
      OP_SLL:   r = a << sh;
      OP_SRL:   r = a >> sh;
      OP_SRA:   r = sa >>> sh;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic                    accept;
  logic                    is_basic;
  logic signed [WIDTH-1:0] sa_c;
  logic signed [WIDTH-1:0] sb_c;
  logic                    slt_c;
  logic                    sltu_c;
  logic [WIDTH-1:0]        basic_res;
  logic [WIDTH-1:0]        imm_res;
  logic                    imm_ill;
  logic                    start_iter;

  assign accept    = in_valid && (state == IDLE);
  assign is_basic  = (ALUControl <= OP_SRA);
  assign sa_c      = SrcA;
  assign sb_c      = SrcB;
  assign slt_c     = (sa_c < sb_c);
  assign sltu_c    = (SrcA < SrcB);
  assign basic_res = basic_op(ALUControl, SrcA, SrcB);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  logic             is_md;
  logic             is_div;
  logic             op_rem;
  logic             op_uns;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] special_res;

  // opcode 1_0xxx: bit2 selects divide, bit1 remainder, bit0 unsigned
  assign is_md    = (ALUControl[4:3] == 2'b10);
  assign is_div   = ALUControl[2];
  assign op_rem   = ALUControl[1];
  assign op_uns   = ALUControl[0];
  assign div_zero = is_md && is_div && (SrcB == '0);
  assign div_ovf  = is_md && is_div && !op_uns && (SrcA == MIN_VAL) && (SrcB == '1);
  assign start_iter = is_md && !div_zero && !div_ovf;

  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    if (is_div) begin
      a_neg = !op_uns && SrcA[WIDTH-1];
      b_neg = !op_uns && SrcB[WIDTH-1];
    end else begin
      // MULH and MULHSU take A as signed, only MULH takes B as signed;
      // MUL's low half is identical for any signedness.
      a_neg = ((ALUControl[1:0] == 2'b01) || (ALUControl[1:0] == 2'b10)) && SrcA[WIDTH-1];
      b_neg = (ALUControl[1:0] == 2'b01) && SrcB[WIDTH-1];
    end
  end

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = op_rem ? SrcA : '1;
    else if (div_ovf) special_res = op_rem ? '0 : MIN_VAL;
  end

  // iteration state (stage p0): hi/lo hold partial product or remainder/quotient
  logic [WIDTH-1:0] hi_p0, lo_p0, opnd_p0;
  logic [SHW-1:0]   cnt_p0;
  logic             div_p0, rem_p0, mullo_p0, negq_p0, negr_p0;
  logic             slt_p0, sltu_p0;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   hi_n, lo_n, md_res;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic               last_iter;

  assign last_iter = (cnt_p0 == LAST);

  always_comb begin
    mul_sum   = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opnd_p0} : '0);
    div_shift = {hi_p0, lo_p0[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_p0};
    if (div_p0) begin
      if (!div_trial[WIDTH]) begin
        hi_n = div_trial[WIDTH-1:0];
        lo_n = {lo_p0[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_shift[WIDTH-1:0];
        lo_n = {lo_p0[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_p0[WIDTH-1:1]};
    end
    // sign fix-up applied to the final iteration's outcome
    prod_mag = {hi_n, lo_n};
    prod_fix = negq_p0 ? ((~prod_mag) + (2*WIDTH)'(1)) : prod_mag;
    if (div_p0) begin
      if (rem_p0) md_res = negr_p0 ? neg_w(hi_n) : hi_n;
      else        md_res = negq_p0 ? neg_w(lo_n) : lo_n;
    end else begin
      md_res = mullo_p0 ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_p0    <= '0;
      lo_p0    <= '0;
      opnd_p0  <= '0;
      cnt_p0   <= '0;
      div_p0   <= 1'b0;
      rem_p0   <= 1'b0;
      mullo_p0 <= 1'b0;
      negq_p0  <= 1'b0;
      negr_p0  <= 1'b0;
      slt_p0   <= 1'b0;
      sltu_p0  <= 1'b0;
    end else if (accept && start_iter) begin
      hi_p0    <= '0;
      lo_p0    <= a_neg ? neg_w(SrcA) : SrcA;
      opnd_p0  <= b_neg ? neg_w(SrcB) : SrcB;
      cnt_p0   <= '0;
      div_p0   <= is_div;
      rem_p0   <= op_rem;
      mullo_p0 <= (ALUControl[1:0] == 2'b00);
      negq_p0  <= a_neg ^ b_neg;
      negr_p0  <= a_neg;
      slt_p0   <= slt_c;
      sltu_p0  <= sltu_c;
    end else if (state == BUSY) begin
      hi_p0  <= hi_n;
      lo_p0  <= lo_n;
      cnt_p0 <= cnt_p0 + SHW'(1);
    end
  end
`else
  assign start_iter = 1'b0;
`endif

  always_comb begin
    imm_res = is_basic ? basic_res : '0;
    imm_ill = !is_basic;
`ifdef SEQ_ALU_MULDIV_EN
    if (is_md) begin
      imm_res = special_res;
      imm_ill = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
`ifdef SEQ_ALU_MULDIV_EN
      IDLE: if (in_valid) state_n = start_iter ? BUSY : DONE;
      BUSY: if (last_iter) state_n = DONE;
`else
      IDLE: if (in_valid) state_n = DONE;
`endif
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // output stage: Result and flags written together, held through DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Result       <= '0;
      Zero         <= 1'b0;
      SignedLess   <= 1'b0;
      UnsignedLess <= 1'b0;
      Illegal      <= 1'b0;
    end else if (accept && !start_iter) begin
      Result       <= imm_res;
      Zero         <= (imm_res == '0);
      SignedLess   <= slt_c;
      UnsignedLess <= sltu_c;
      Illegal      <= imm_ill;
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if ((state == BUSY) && last_iter) begin
      Result       <= md_res;
      Zero         <= (md_res == '0);
      SignedLess   <= slt_p0;
      UnsignedLess <= sltu_p0;
      Illegal      <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [4:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Zero;
  logic         SignedLess;
  logic         UnsignedLess;
  logic         Illegal;

  int checks = 0;
  int errors = 0;

  // flags packed as {Zero, SignedLess, UnsignedLess, Illegal}
  typedef struct { logic [W-1:0] res; logic [3:0] flags; int lat; } exp_t;
  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Zero(Zero), .SignedLess(SignedLess), .UnsignedLess(UnsignedLess), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // {op, A, B}
  logic [68:0] basic_v [15] = '{
    {5'h00, 32'h7FFFFFFF, 32'h00000001}, {5'h00, 32'hFFFFFFFF, 32'h00000001},
    {5'h01, 32'h00000005, 32'h00000005}, {5'h01, 32'h00000000, 32'h00000001},
    {5'h02, 32'hFF00FF00, 32'h0FF00FF0}, {5'h03, 32'hF0000000, 32'h0000000F},
    {5'h04, 32'hAAAA5555, 32'hFFFF0000}, {5'h05, 32'h00000001, 32'hFFFFFFFF},
    {5'h06, 32'hFFFFFFFF, 32'h00000001}, {5'h06, 32'h00000001, 32'hFFFFFFFF},
    {5'h07, 32'h12345678, 32'hCAFEBABE}, {5'h08, 32'h00000001, 32'h0000003F},
    {5'h09, 32'h80000000, 32'h00000024}, {5'h0A, 32'h80000000, 32'h00000024},
    {5'h0A, 32'h7FFFFFF0, 32'h00000004}};

  logic [68:0] md_v [17] = '{
    {5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF}, {5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF},
    {5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF}, {5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF},
    {5'h10, 32'h12345678, 32'h9ABCDEF0}, {5'h11, 32'h80000000, 32'h80000000},
    {5'h14, 32'h80000000, 32'hFFFFFFFF}, {5'h16, 32'h80000000, 32'hFFFFFFFF},
    {5'h17, 32'h0000000D, 32'h00000000}, {5'h15, 32'h00000005, 32'h00000000},
    {5'h14, 32'hFFFFFFF9, 32'h00000002}, {5'h16, 32'hFFFFFFF9, 32'h00000002},
    {5'h15, 32'hFFFFFFFF, 32'h00000003}, {5'h1F, 32'h00001234, 32'h00000001},
    {5'h0B, 32'h00000001, 32'h00000001}, {5'h0F, 32'h00000002, 32'h00000003},
    {5'h18, 32'hFFFFFFFF, 32'hFFFFFFFF}};

  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    logic [4:0] sh;
    logic ill;
`ifdef SEQ_ALU_MULDIV_EN
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    logic [63:0] p;
`endif
    sa = a; sbv = b; sh = b[4:0];
    e.res = '0; e.lat = 1; ill = 1'b0;
    case (op)
      5'h00: e.res = a + b;
      5'h01: e.res = a - b;
      5'h02: e.res = a & b;
      5'h03: e.res = a | b;
      5'h04: e.res = a ^ b;
      5'h05: e.res = (a < b) ? 32'd1 : 32'd0;
      5'h06: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      5'h07: e.res = b;
      5'h08: e.res = a << sh;
      5'h09: e.res = a >> sh;
      5'h0A: e.res = sa >>> sh;
`ifdef SEQ_ALU_MULDIV_EN
      5'h10: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; e.lat = W + 1; end
      5'h11: begin pa = sa; pb = sbv; p = pa * pb; e.res = p[63:32]; e.lat = W + 1; end
      5'h12: begin pa = sa; pb = {32'b0, b}; p = pa * pb; e.res = p[63:32]; e.lat = W + 1; end
      5'h13: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; e.lat = W + 1; end
      5'h14: if (b == 0) e.res = '1;
             else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.res = a;
             else begin e.res = sa / sbv; e.lat = W + 1; end
      5'h15: if (b == 0) e.res = '1; else begin e.res = a / b; e.lat = W + 1; end
      5'h16: if (b == 0) e.res = a;
             else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.res = '0;
             else begin e.res = sa % sbv; e.lat = W + 1; end
      5'h17: if (b == 0) e.res = a; else begin e.res = a % b; e.lat = W + 1; end
`endif
      default: ill = 1'b1;
    endcase
    e.flags = {e.res == '0, sa < sbv, a < b, ill};
    return e;
  endfunction

  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 5'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk); lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; ALUControl = '0;
    repeat (3) @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL reset_handshake: got {out_valid,in_ready}=%b expected 01", {out_valid, in_ready}); end
    checks++; if (Result !== '0) begin errors++;
      $display("FAIL reset_result: got %h expected 0", Result); end
    checks++; if ({Zero, SignedLess, UnsignedLess, Illegal} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {Zero, SignedLess, UnsignedLess, Illegal}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL post_reset_idle: got {out_valid,in_ready}=%b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_basic();
    int lat; bit rs; exp_t e; logic [68:0] v;
    foreach (basic_v[i]) begin
      v = basic_v[i];
      send(v[68:64], v[63:32], v[31:0]);
      wait_out(lat, rs);
      e = sb.pop_front();
      checks++; if (Result !== e.res) begin errors++;
        $display("FAIL basic[%0d] op=%h result: got %h expected %h", i, v[68:64], Result, e.res); end
      checks++; if ({Zero, SignedLess, UnsignedLess, Illegal} !== e.flags) begin errors++;
        $display("FAIL basic[%0d] op=%h flags: got %b expected %b", i, v[68:64],
                 {Zero, SignedLess, UnsignedLess, Illegal}, e.flags); end
      checks++; if (lat !== e.lat) begin errors++;
        $display("FAIL basic[%0d] op=%h latency: got %0d expected %0d", i, v[68:64], lat, e.lat); end
      release_out();
    end
  endtask

  task automatic test_muldiv();
    int lat; bit rs; exp_t e; logic [68:0] v;
    foreach (md_v[i]) begin
      v = md_v[i];
      send(v[68:64], v[63:32], v[31:0]);
      wait_out(lat, rs);
      e = sb.pop_front();
      checks++; if (Result !== e.res) begin errors++;
        $display("FAIL muldiv[%0d] op=%h result: got %h expected %h", i, v[68:64], Result, e.res); end
      checks++; if ({Zero, SignedLess, UnsignedLess, Illegal} !== e.flags) begin errors++;
        $display("FAIL muldiv[%0d] op=%h flags: got %b expected %b", i, v[68:64],
                 {Zero, SignedLess, UnsignedLess, Illegal}, e.flags); end
      checks++; if (lat !== e.lat) begin errors++;
        $display("FAIL muldiv[%0d] op=%h latency: got %0d expected %0d", i, v[68:64], lat, e.lat); end
      checks++; if (rs !== 1'b0) begin errors++;
        $display("FAIL muldiv[%0d] op=%h in_ready_while_busy: got 1 expected 0", i, v[68:64]); end
      release_out();
    end
  endtask

  task automatic test_hold();
    int lat; bit rs; exp_t e;
    send(5'h04, 32'hF0F0F0F0, 32'h0F0F0F0F);
    wait_out(lat, rs);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); ALUControl = 5'h00; SrcA = 32'd1; SrcB = 32'd1;
      @(negedge clk);
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++;
        $display("FAIL hold[%0d] handshake: got {out_valid,in_ready}=%b expected 10", i, {out_valid, in_ready}); end
      checks++; if (Result !== e.res || {Zero, SignedLess, UnsignedLess, Illegal} !== e.flags) begin errors++;
        $display("FAIL hold[%0d] held_value: got %h/%b expected %h/%b", i, Result,
                 {Zero, SignedLess, UnsignedLess, Illegal}, e.res, e.flags); end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL hold_release: got {out_valid,in_ready}=%b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_abort();
    int lat; bit rs; exp_t e;
`ifdef SEQ_ALU_MULDIV_EN
    send(5'h15, 32'd100000, 32'd7);
    repeat (8) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL abort_busy: got out_valid=%b expected 0", out_valid); end
`else
    send(5'h01, 32'd1, 32'd2);
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL abort_pending: got out_valid=%b expected 1", out_valid); end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_front());
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
      $display("FAIL abort_handshake: got {out_valid,in_ready}=%b expected 01", {out_valid, in_ready}); end
    checks++; if (Result !== '0 || {Zero, SignedLess, UnsignedLess, Illegal} !== 4'b0000) begin errors++;
      $display("FAIL abort_cleared: got %h/%b expected 0/0000", Result, {Zero, SignedLess, UnsignedLess, Illegal}); end
    send(5'h00, 32'd3, 32'd4);
    wait_out(lat, rs);
    e = sb.pop_front();
    checks++; if (Result !== e.res || lat !== e.lat) begin errors++;
      $display("FAIL abort_recover: got %h lat %0d expected %h lat %0d", Result, lat, e.res, e.lat); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc; bit overlap; exp_t e; logic [4:0] op; logic [W-1:0] a, b;
    sent = 0; got = 0; cyc = 0; overlap = 1'b0;
    out_ready = 1'b1;
    while (got < 20 && cyc < 400) begin
      if (in_ready) begin
        if (sent < 20) begin
          op = 5'($urandom_range(0, 10)); a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : $urandom;
          ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
          sb.push_back(model(op, a, b));
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk); cyc++;
      if (out_valid && in_ready) overlap = 1'b1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b unexpected_output: got result %h expected none", Result);
        end else begin
          e = sb.pop_front();
          checks++; if (Result !== e.res || {Zero, SignedLess, UnsignedLess, Illegal} !== e.flags) begin errors++;
            $display("FAIL b2b[%0d] result: got %h/%b expected %h/%b", got, Result,
                     {Zero, SignedLess, UnsignedLess, Illegal}, e.res, e.flags); end
        end
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (got !== 20 || sb.size() !== 0) begin errors++;
      $display("FAIL b2b_count: got %0d results (%0d pending) expected 20 (0)", got, sb.size()); end
    checks++; if (overlap !== 1'b0) begin errors++;
      $display("FAIL b2b_overlap: got in_ready with out_valid expected never"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_muldiv();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
